rv32i_decode: RTL and testbench
===============================

Name: rv32i_decode

Overview:
- Single-stage RV32I instruction decoder; sits directly after the fetch stage, receiving the fetched PC and the 32-bit little-endian-assembled instruction word.
- Registers fully decoded fields, sign-extended immediate, ALU op and control strobes for the execute stage.
- Flags any encoding outside RV32I base (no FENCE/SYSTEM) as illegal.

Parameters:
- XLEN, 32, datapath/word width; only 32 is supported.

Ports:
- clk_i  in  1  clock, rising-edge.
- rst_i  in  1  reset; asynchronous and active-high.
- pc_i  in  32  PC of instr_i (types::word_t).
- instr_i  in  32  raw instruction word.
- valid_o  out  1  registered outputs hold a decoded instruction.
- pc_o  out  32  registered copy of pc_i.
- rd_o  out  5  instr[11:7].
- rs1_o  out  5  instr[19:15].
- rs2_o  out  5  instr[24:20].
- funct3_o  out  3  instr[14:12].
- imm_o  out  32  sign-extended immediate for the instruction's format; 0 for R-type/illegal.
- alu_op_o  out  4  alu_op_t enum.
- reg_write_o  out  1  writes rd (forced 0 when rd==0).
- mem_read_o / mem_write_o  out  1 each  load / store.
- branch_o / jump_o  out  1 each  conditional branch / JAL or JALR.
- use_imm_o  out  1  ALU operand B is imm_o.
- use_pc_o  out  1  ALU operand A is PC (AUIPC, JAL).
- illegal_o  out  1  unsupported or malformed encoding.

Behaviour:
- Combinational decode of instr_i; all outputs registered on posedge clk_i. Latency: 1 cycle.
- rst_i asserted (asynchronously): every output 0, including valid_o and illegal_o.
- First posedge after reset release: valid_o=1. valid_o then stays 1 every cycle; a new instruction is decoded every cycle with no stall.
- Reset mid-stream clears all outputs immediately, without waiting for a clock edge.
- Immediate formats:
  - I: instr[31:20] sign-extended.
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - All are sign-extended from the top bit.
- Opcode map:
  - LUI: alu PASS_B, imm U.
  - AUIPC: ADD, use_pc.
  - JAL: jump, use_pc, imm J.
  - JALR: jump, imm I; requires funct3 000.
  - BRANCH: funct3 in {000,001,100,101,110,111}, alu SUB/SLT/SLTU, no reg_write.
  - LOAD: funct3 in {000,001,010,100,101}, ADD, mem_read.
  - STORE: funct3 in {000,001,010}, ADD, mem_write.
  - OP-IMM: SLLI requires funct7 0000000; SRLI/SRAI require funct7 0000000/0100000.
  - OP: funct7 0000000, or 0100000 for SUB/SRA only.
- illegal_o=1 when any of these hold:
  - instr[1:0]!=11;
  - unknown opcode;
  - invalid funct3/funct7 for the opcode.
- When illegal: reg_write/mem_read/mem_write/branch/jump are 0 and imm_o=0. Field outputs rd/rs1/rs2/funct3 and pc_o still pass through.
- 0x00000000 and 0xFFFFFFFF are illegal.

Decomposition:
- Package types: word_t (32-bit), reg_idx_t (5-bit), alu_op_t enum (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B), opcode_t localparams.
- Package addressing: BaseAddress.
- One natural sub-module: rv32i_imm_gen (combinational format select + sign extension).

Test Plan:
- Reset: assert rst_i between clock edges -> all outputs 0 immediately. Release, then one edge -> valid_o=1.
- addi x1,x0,5 (0x00500093) -> rd=1, rs1=0, imm=5, ADD, reg_write=1, use_imm=1. Then sub x3,x1,x2 (0x402081B3) -> rd=3, rs1=1, rs2=2, SUB, use_imm=0.
- sw x2,8(x1) (0x0020A423) -> imm=8, mem_write=1, reg_write=0. Then lui x5,0x12345 (0x123452B7) -> imm=0x12345000, PASS_B.
- beq x0,x0,-4 (0xFE000EE3) -> branch=1, imm=0xFFFFFFFC. Then jal x1,+8 (0x008000EF) -> jump=1, use_pc=1, imm=8, reg_write=1.
- Illegal: 0x00000000, 0x0000707F, add with funct7 0100001 -> illegal_o=1, all strobes 0. addi x0,x0,0 (0x00000013) -> legal, reg_write=0.
- Back-to-back stream of 16 random legal instructions -> each decoded exactly 1 cycle later, pc_o tracking pc_i.

Source files
------------

// File: rtl/rv32i_decode_pkg.sv
// Shared types for the RV32I decode slice: word/register types, the ALU
// operation encoding handed to execute, immediate format selectors and the
// base opcode map.
package rv32i_decode_pkg;

    localparam int WordWidth = 32;

    // Reset vector and start of the instruction address space.
    localparam logic [31:0] BaseAddress = 32'h0000_0000;

    typedef logic [WordWidth-1:0] word_t;
    typedef logic [4:0]           reg_idx_t;
    typedef logic [6:0]           opcode_t;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_t;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_t;

    localparam opcode_t OPC_LUI    = 7'b0110111;
    localparam opcode_t OPC_AUIPC  = 7'b0010111;
    localparam opcode_t OPC_JAL    = 7'b1101111;
    localparam opcode_t OPC_JALR   = 7'b1100111;
    localparam opcode_t OPC_BRANCH = 7'b1100011;
    localparam opcode_t OPC_LOAD   = 7'b0000011;
    localparam opcode_t OPC_STORE  = 7'b0100011;
    localparam opcode_t OPC_OPIMM  = 7'b0010011;
    localparam opcode_t OPC_OP     = 7'b0110011;

    // Arithmetic funct3 table shared by OP and OP-IMM; 'alt' selects the
    // funct7[5] variant (SUB instead of ADD, SRA instead of SRL).
    function automatic alu_op_t aluFromFunct3(input logic [2:0] funct3, input logic alt);
        alu_op_t op;
        op = ALU_ADD;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv32i_imm_gen.sv
// Immediate generator: picks the bit scatter for the selected instruction
// format and sign-extends from instr[31]. IMM_NONE yields zero.
module rv32i_imm_gen
    import rv32i_decode_pkg::*;
(
    input  logic [31:0] instr_i,
    input  logic [2:0]  fmt_i,
    output logic [31:0] imm_o
);

    // Format select; every format takes its sign from instr[31].
    always_comb begin
        imm_o = '0;
        case (fmt_i)
            IMM_I:   imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S:   imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B:   imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                              instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_U:   imm_o = {instr_i[31:12], 12'b0};
            IMM_J:   imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                              instr_i[20], instr_i[30:21], 1'b0};
            default: imm_o = '0;
        endcase
    end

endmodule

// File: rtl/rv32i_decode.sv
// Single-stage RV32I decoder between fetch and execute. Decodes instr_i
// combinationally and registers every field and control strobe, so execute
// sees the decoded instruction one cycle after fetch presents it.
module rv32i_decode
    import rv32i_decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [31:0]     instr_i,
    output logic            valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [4:0]      rd_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [2:0]      funct3_o,
    output logic [XLEN-1:0] imm_o,
    output logic [3:0]      alu_op_o,
    output logic            reg_write_o,
    output logic            mem_read_o,
    output logic            mem_write_o,
    output logic            branch_o,
    output logic            jump_o,
    output logic            use_imm_o,
    output logic            use_pc_o,
    output logic            illegal_o
);

    opcode_t     opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        legal;
    imm_fmt_t    immFmt;
    logic [31:0] imm_d;
    alu_op_t     alu_d;
    logic        regWrite_d, memRead_d, memWrite_d, branch_d, jump_d, useImm_d, usePc_d;

    logic            valid_q, illegal_q;
    logic [XLEN-1:0] pc_q, imm_q;
    reg_idx_t        rd_q, rs1_q, rs2_q;
    logic [2:0]      funct3_q;
    alu_op_t         alu_q;
    logic            regWrite_q, memRead_q, memWrite_q, branch_q, jump_q, useImm_q, usePc_q;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    // Opcode/funct decode; an illegal encoding drops every strobe and the immediate.
    always_comb begin
        legal      = 1'b0;
        immFmt     = IMM_NONE;
        alu_d      = ALU_ADD;
        regWrite_d = 1'b0;
        memRead_d  = 1'b0;
        memWrite_d = 1'b0;
        branch_d   = 1'b0;
        jump_d     = 1'b0;
        useImm_d   = 1'b0;
        usePc_d    = 1'b0;
        case (opcode)
            OPC_LUI: begin
                legal = 1'b1; immFmt = IMM_U; alu_d = ALU_PASS_B;
                regWrite_d = 1'b1; useImm_d = 1'b1;
            end
            OPC_AUIPC: begin
                legal = 1'b1; immFmt = IMM_U;
                regWrite_d = 1'b1; useImm_d = 1'b1; usePc_d = 1'b1;
            end
            OPC_JAL: begin
                legal = 1'b1; immFmt = IMM_J;
                regWrite_d = 1'b1; jump_d = 1'b1; useImm_d = 1'b1; usePc_d = 1'b1;
            end
            OPC_JALR: begin
                legal = (funct3 == 3'b000); immFmt = IMM_I;
                regWrite_d = 1'b1; jump_d = 1'b1; useImm_d = 1'b1;
            end
            OPC_BRANCH: begin
                legal = (funct3 != 3'b010) && (funct3 != 3'b011);
                immFmt = IMM_B; branch_d = 1'b1;
                if (funct3[2] == 1'b0)      alu_d = ALU_SUB;
                else if (funct3[1] == 1'b0) alu_d = ALU_SLT;
                else                        alu_d = ALU_SLTU;
            end
            OPC_LOAD: begin
                legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
                immFmt = IMM_I; memRead_d = 1'b1; regWrite_d = 1'b1; useImm_d = 1'b1;
            end
            OPC_STORE: begin
                legal = funct3 inside {3'b000, 3'b001, 3'b010};
                immFmt = IMM_S; memWrite_d = 1'b1; useImm_d = 1'b1;
            end
            OPC_OPIMM: begin
                immFmt = IMM_I; regWrite_d = 1'b1; useImm_d = 1'b1;
                alu_d = aluFromFunct3(funct3, (funct3 == 3'b101) && funct7[5]);
                if (funct3 == 3'b001)      legal = (funct7 == 7'b0000000);
                else if (funct3 == 3'b101) legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                else                       legal = 1'b1;
            end
            OPC_OP: begin
                regWrite_d = 1'b1;
                alu_d = aluFromFunct3(funct3, funct7[5]);
                legal = (funct7 == 7'b0000000) ||
                        ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            end
            default: legal = 1'b0;
        endcase
        if (instr_i[1:0] != 2'b11) begin
            legal = 1'b0;
        end
        if (!legal) begin
            immFmt     = IMM_NONE;
            alu_d      = ALU_ADD;
            regWrite_d = 1'b0;
            memRead_d  = 1'b0;
            memWrite_d = 1'b0;
            branch_d   = 1'b0;
            jump_d     = 1'b0;
            useImm_d   = 1'b0;
            usePc_d    = 1'b0;
        end
        if (instr_i[11:7] == 5'd0) begin
            regWrite_d = 1'b0;
        end
    end

    rv32i_imm_gen u_imm_gen (
        .instr_i (instr_i),
        .fmt_i   (immFmt),
        .imm_o   (imm_d)
    );

    // Pipeline register toward execute; reset clears everything at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q    <= 1'b0;
            illegal_q  <= 1'b0;
            pc_q       <= '0;
            imm_q      <= '0;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            funct3_q   <= '0;
            alu_q      <= ALU_ADD;
            regWrite_q <= 1'b0;
            memRead_q  <= 1'b0;
            memWrite_q <= 1'b0;
            branch_q   <= 1'b0;
            jump_q     <= 1'b0;
            useImm_q   <= 1'b0;
            usePc_q    <= 1'b0;
        end else begin
            valid_q    <= 1'b1;
            illegal_q  <= !legal;
            pc_q       <= pc_i;
            imm_q      <= imm_d;
            rd_q       <= instr_i[11:7];
            rs1_q      <= instr_i[19:15];
            rs2_q      <= instr_i[24:20];
            funct3_q   <= funct3;
            alu_q      <= alu_d;
            regWrite_q <= regWrite_d;
            memRead_q  <= memRead_d;
            memWrite_q <= memWrite_d;
            branch_q   <= branch_d;
            jump_q     <= jump_d;
            useImm_q   <= useImm_d;
            usePc_q    <= usePc_d;
        end
    end

    assign valid_o     = valid_q;
    assign illegal_o   = illegal_q;
    assign pc_o        = pc_q;
    assign imm_o       = imm_q;
    assign rd_o        = rd_q;
    assign rs1_o       = rs1_q;
    assign rs2_o       = rs2_q;
    assign funct3_o    = funct3_q;
    assign alu_op_o    = alu_q;
    assign reg_write_o = regWrite_q;
    assign mem_read_o  = memRead_q;
    assign mem_write_o = memWrite_q;
    assign branch_o    = branch_q;
    assign jump_o      = jump_q;
    assign use_imm_o   = useImm_q;
    assign use_pc_o    = usePc_q;

endmodule

// File: tb/tb_rv32i_decode.sv
// Bench for rv32i_decode: a driver pushes the reference decode of every
// instruction it presents into a queue, and a monitor pops and compares one
// entry per clock while the decoder output is valid.
module tb_rv32i_decode;
    import rv32i_decode_pkg::*;

    logic        clk_i;
    logic        rst_i;
    logic [31:0] pc_i;
    logic [31:0] instr_i;
    logic        valid_o;
    logic [31:0] pc_o;
    logic [4:0]  rd_o, rs1_o, rs2_o;
    logic [2:0]  funct3_o;
    logic [31:0] imm_o;
    logic [3:0]  alu_op_o;
    logic        reg_write_o, mem_read_o, mem_write_o, branch_o, jump_o;
    logic        use_imm_o, use_pc_o, illegal_o;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic        rw, mr, mw, br, jp, ui, up, ill;
    } out_t;

    out_t        expQ[$];
    int          testsRun  = 0;
    int          failCount = 0;
    logic        monitorOn = 1'b0;
    logic [31:0] pcNext    = BaseAddress;
    alu_op_t     opTable[8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU,
                                ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};

    rv32i_decode #(.XLEN(32)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .pc_i        (pc_i),
        .instr_i     (instr_i),
        .valid_o     (valid_o),
        .pc_o        (pc_o),
        .rd_o        (rd_o),
        .rs1_o       (rs1_o),
        .rs2_o       (rs2_o),
        .funct3_o    (funct3_o),
        .imm_o       (imm_o),
        .alu_op_o    (alu_op_o),
        .reg_write_o (reg_write_o),
        .mem_read_o  (mem_read_o),
        .mem_write_o (mem_write_o),
        .branch_o    (branch_o),
        .jump_o      (jump_o),
        .use_imm_o   (use_imm_o),
        .use_pc_o    (use_pc_o),
        .illegal_o   (illegal_o)
    );

    // Free-running 10-unit clock.
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Reference decode built from the ISA rules, immediates by shift/mask arithmetic.
    function automatic out_t model(input logic [31:0] w, input logic [31:0] pc);
        out_t        e;
        logic [31:0] sgn, iI, iS, iB, iU, iJ;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        logic        ok;
        e = '0;
        e.valid = 1'b1;
        e.pc  = pc;
        e.rd  = w[11:7];
        e.rs1 = w[19:15];
        e.rs2 = w[24:20];
        e.f3  = w[14:12];
        op = w[6:0];
        f3 = w[14:12];
        f7 = w[31:25];
        sgn = $signed(w) >>> 31;
        iI  = $signed(w) >>> 20;
        iS  = (iI & ~32'h1F) | ((w >> 7) & 32'h1F);
        iB  = (sgn & 32'hFFFF_F000) | (((w >> 7) & 32'h1) << 11) |
              (((w >> 25) & 32'h3F) << 5) | (((w >> 8) & 32'hF) << 1);
        iU  = w & 32'hFFFF_F000;
        iJ  = (sgn & 32'hFFF0_0000) | (w & 32'h000F_F000) |
              (((w >> 20) & 32'h1) << 11) | (((w >> 21) & 32'h3FF) << 1);
        ok = 1'b0;
        e.alu = ALU_ADD;
        case (op)
            7'h37: begin ok = 1'b1; e.imm = iU; e.alu = ALU_PASS_B; e.rw = 1'b1; e.ui = 1'b1; end
            7'h17: begin ok = 1'b1; e.imm = iU; e.rw = 1'b1; e.ui = 1'b1; e.up = 1'b1; end
            7'h6F: begin ok = 1'b1; e.imm = iJ; e.rw = 1'b1; e.jp = 1'b1; e.ui = 1'b1; e.up = 1'b1; end
            7'h67: begin ok = (f3 == 3'd0); e.imm = iI; e.rw = 1'b1; e.jp = 1'b1; e.ui = 1'b1; end
            7'h63: begin
                ok = (f3 != 3'd2) && (f3 != 3'd3);
                e.imm = iB; e.br = 1'b1;
                e.alu = (f3 < 3'd4) ? ALU_SUB : ((f3 < 3'd6) ? ALU_SLT : ALU_SLTU);
            end
            7'h03: begin
                ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
                e.imm = iI; e.mr = 1'b1; e.rw = 1'b1; e.ui = 1'b1;
            end
            7'h23: begin ok = (f3 <= 3'd2); e.imm = iS; e.mw = 1'b1; e.ui = 1'b1; end
            7'h13: begin
                e.imm = iI; e.rw = 1'b1; e.ui = 1'b1; e.alu = opTable[f3];
                if (f3 == 3'd1)      ok = (f7 == 7'h00);
                else if (f3 == 3'd5) ok = (f7 == 7'h00) || (f7 == 7'h20);
                else                 ok = 1'b1;
                if (f3 == 3'd5 && f7 == 7'h20) e.alu = ALU_SRA;
            end
            7'h33: begin
                e.rw = 1'b1; e.alu = opTable[f3];
                ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                if (f7 == 7'h20) e.alu = (f3 == 3'd0) ? ALU_SUB : ALU_SRA;
            end
            default: ok = 1'b0;
        endcase
        if (w[1:0] != 2'b11) ok = 1'b0;
        if (!ok) begin
            e.imm = '0; e.alu = ALU_ADD;
            {e.rw, e.mr, e.mw, e.br, e.jp, e.ui, e.up} = '0;
        end
        if (e.rd == 5'd0) e.rw = 1'b0;
        e.ill = !ok;
        return e;
    endfunction

    // Random instruction that is guaranteed legal for a randomly chosen opcode.
    function automatic logic [31:0] genLegal();
        logic [31:0] w;
        logic [2:0]  f3;
        int          k;
        w  = $urandom;
        k  = $urandom_range(0, 8);
        f3 = w[14:12];
        case (k)
            0: w[6:0] = 7'h37;
            1: w[6:0] = 7'h17;
            2: w[6:0] = 7'h6F;
            3: begin w[6:0] = 7'h67; w[14:12] = 3'd0; end
            4: begin w[6:0] = 7'h63; if (f3[2:1] == 2'b01) w[14] = 1'b1; end
            5: begin w[6:0] = 7'h03; if (f3 == 3'd3 || f3 >= 3'd6) w[14:12] = 3'd2; end
            6: begin w[6:0] = 7'h23; w[14] = 1'b0; if (f3[1:0] == 2'b11) w[13] = 1'b0; end
            7: begin
                w[6:0] = 7'h13;
                if (f3 == 3'd1) w[31:25] = 7'h00;
                if (f3 == 3'd5) w[31:25] = w[30] ? 7'h20 : 7'h00;
            end
            default: begin
                w[6:0] = 7'h33;
                w[31:25] = (w[30] && (f3 == 3'd0 || f3 == 3'd5)) ? 7'h20 : 7'h00;
            end
        endcase
        return w;
    endfunction

    function automatic out_t sampleDut();
        out_t a;
        a = {valid_o, pc_o, rd_o, rs1_o, rs2_o, funct3_o, imm_o, alu_op_o,
             reg_write_o, mem_read_o, mem_write_o, branch_o, jump_o,
             use_imm_o, use_pc_o, illegal_o};
        return a;
    endfunction

    // Present one instruction for the coming edge and record its expected decode.
    task automatic applyStimulus(input logic [31:0] w);
        instr_i = w;
        pc_i    = pcNext;
        expQ.push_back(model(w, pcNext));
        pcNext  = pcNext + 32'd4;
        @(negedge clk_i);
    endtask

    task automatic checkOutput(input out_t exp);
        out_t act;
        act = sampleDut();
        testsRun++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL decode pc=%h imm act=%h exp=%h alu act=%0d exp=%0d flags(rw,mr,mw,br,jp,ui,up,ill) act=%b exp=%b all act=%h exp=%h",
                     exp.pc, act.imm, exp.imm, act.alu, exp.alu, act[7:0], exp[7:0], act, exp);
        end
    endtask

    task automatic checkReset(input string name);
        out_t act;
        act = sampleDut();
        testsRun++;
        if (act !== '0) begin
            failCount++;
            $display("[TB] FAIL %s outputs act=%h exp=0", name, act);
        end
    endtask

    // Monitor: one decoded result per clock while out of reset.
    always @(posedge clk_i) begin
        #1;
        if (monitorOn && !rst_i) begin
            if (expQ.size() == 0) begin
                testsRun++;
                failCount++;
                $display("[TB] FAIL unexpected_output act=%h exp=none", sampleDut());
            end else begin
                checkOutput(expQ.pop_front());
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog act=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed cases, mid-stream reset, then random streams.
    initial begin
        rst_i   = 1'b0;
        instr_i = '0;
        pc_i    = '0;
        #2 rst_i = 1'b1;
        #1 checkReset("power_on_reset");
        repeat (2) @(negedge clk_i);
        rst_i     = 1'b0;
        monitorOn = 1'b1;

        applyStimulus(32'h0050_0093);
        applyStimulus(32'h4020_81B3);
        applyStimulus(32'h0020_A423);
        applyStimulus(32'h1234_52B7);
        applyStimulus(32'hFE00_0EE3);
        applyStimulus(32'h0080_00EF);
        applyStimulus(32'h0000_0000);
        applyStimulus(32'h0000_707F);
        applyStimulus(32'h4231_00B3);
        applyStimulus(32'h0000_0013);
        applyStimulus(32'hFFFF_FFFF);

        #2 rst_i = 1'b1;
        #1 checkReset("mid_stream_reset");
        @(negedge clk_i);
        rst_i  = 1'b0;
        pcNext = $urandom & 32'hFFFF_FFFC;

        for (int i = 0; i < 16; i++) applyStimulus(genLegal());
        for (int i = 0; i < 24; i++) applyStimulus($urandom);

        monitorOn = 1'b0;
        testsRun++;
        if (expQ.size() != 0) begin
            failCount++;
            $display("[TB] FAIL pending_expectations act=%0d exp=0", expQ.size());
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
